// File: rtl/forwarded_count_rate_pkg.sv
// forwarded_count_rate_pkg
// Shared definitions for the forwarded-count rate meter:
//   - state_e            : PRIME (waiting for the first baseline) / RUN
//   - MAX_COUNT_W        : widest count the helper below accepts
//   - exceeds_rate_width : flags a delta that does not fit in the rate output
package forwarded_count_rate_pkg;

  typedef enum logic {
    STATE_PRIME = 1'b0,
    STATE_RUN   = 1'b1
  } state_e;

  localparam int unsigned MAX_COUNT_W = 64;

  // Saturating width reduction, flag half. The caller zero-extends its delta
  // to MAX_COUNT_W bits; a 1 result means the rate must be clamped to
  // all-ones, a 0 result means the low rate_w bits carry the exact delta.
  function automatic logic exceeds_rate_width(input logic [MAX_COUNT_W-1:0] delta,
                                              input int unsigned            rate_w);
    logic [MAX_COUNT_W-1:0] max_v;
    if (rate_w >= MAX_COUNT_W) begin
      max_v = '1;
    end else begin
      max_v = (64'd1 << rate_w) - 64'd1;
    end
    return (delta > max_v);
  endfunction

endpackage

// File: rtl/forwarded_count_rate_if.sv
// forwarded_count_rate_if
// Bundles the forwarded count, the optional window strobe and the published
// rate results.
//   master : drives count/windowStrobe, observes the results
//   slave  : the rate meter itself
//
// Handshake: there is no ready/backpressure. rateValid is a single-cycle
// strobe; rate/saturated/stalled are meaningful on that cycle and hold their
// value until the next strobe. count is a level sampled only at window edges.
// dbg_state exposes the meter's PRIME/RUN state for observation.
interface forwarded_count_rate_if
  import forwarded_count_rate_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32,
  parameter int unsigned RATE_WIDTH  = 32
) ();

  logic [COUNT_WIDTH-1:0] count;
  logic                   windowStrobe;
  logic [RATE_WIDTH-1:0]  rate;
  logic                   rateValid;
  logic                   saturated;
  logic                   stalled;
  state_e                 dbg_state;

  modport master (
    output count, windowStrobe,
    input  rate, rateValid, saturated, stalled, dbg_state
  );

  modport slave (
    input  count, windowStrobe,
    output rate, rateValid, saturated, stalled, dbg_state
  );

endinterface

// File: rtl/forwarded_count_rate_window_divider.sv
// forwarded_count_rate_window_divider
// Produces the one-cycle window tick.
//   clk, reset      : system clock, synchronous active-high reset
//   window_strobe_i : external window boundary (used when USE_EXT_STROBE=1)
//   tick_o          : window edge; high for one cycle per window
// With the internal divider the counter runs 0..WINDOW_CYCLES-1 and the tick
// is the cycle it sits at WINDOW_CYCLES-1, so windows are exactly
// WINDOW_CYCLES clocks long and restart from 0 after reset.
module forwarded_count_rate_window_divider #(
  parameter int unsigned WINDOW_CYCLES  = 125000000,
  parameter bit          USE_EXT_STROBE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic window_strobe_i,
  output logic tick_o
);

  localparam int unsigned    DIV_W = $clog2(WINDOW_CYCLES);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(WINDOW_CYCLES - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             div_last;

  assign div_last = (div_q == LAST);

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_last) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // In external-strobe mode the divider keeps running but is not observed.
  assign tick_o = USE_EXT_STROBE ? window_strobe_i : div_last;

endmodule

// File: rtl/forwarded_count_rate.sv
// forwarded_count_rate
// Measures the rate of a free-running count forwarded from another clock
// domain: samples the count once per window and publishes the modulo-2^W
// difference between consecutive samples.
//   clk, reset : system clock, synchronous active-high reset
//   bus.count        : forwarded count (stable between updates)
//   bus.windowStrobe : external window boundary when USE_EXT_STROBE=1
//   bus.rate         : delta over the last complete window (clamped)
//   bus.rateValid    : one-cycle pulse when rate updates
//   bus.saturated    : last delta did not fit in RATE_WIDTH bits
//   bus.stalled      : STALL_WINDOWS consecutive zero-delta windows
//   bus.dbg_state    : PRIME/RUN state
// The first window edge after reset only captures the baseline, so the first
// rate appears one full window later; a reset mid-window discards it.
module forwarded_count_rate
  import forwarded_count_rate_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned RATE_WIDTH     = 32,
  parameter int unsigned WINDOW_CYCLES  = 125000000,
  parameter bit          USE_EXT_STROBE = 1'b0,
  parameter int unsigned STALL_WINDOWS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  forwarded_count_rate_if.slave bus
);

  localparam int unsigned SW = $clog2(STALL_WINDOWS + 1);

  logic                   tick;
  state_e                 state_q;
  logic [COUNT_WIDTH-1:0] baseline_q;
  logic [COUNT_WIDTH-1:0] delta;
  logic                   over;
  logic [RATE_WIDTH-1:0]  rate_q;
  logic [RATE_WIDTH-1:0]  rate_d;
  logic                   rate_valid_q;
  logic                   saturated_q;
  logic                   stalled_q;
  logic [SW-1:0]          stall_q;
  logic [SW-1:0]          stall_d;

  forwarded_count_rate_window_divider #(
    .WINDOW_CYCLES  (WINDOW_CYCLES),
    .USE_EXT_STROBE (USE_EXT_STROBE)
  ) u_window_divider (
    .clk             (clk),
    .reset           (reset),
    .window_strobe_i (bus.windowStrobe),
    .tick_o          (tick)
  );

  always_comb begin
    // Unsigned subtraction wraps, so a count that rolled past all-ones
    // still yields the true positive distance.
    delta   = bus.count - baseline_q;
    over    = exceeds_rate_width(MAX_COUNT_W'(delta), RATE_WIDTH);
    rate_d  = over ? {RATE_WIDTH{1'b1}} : delta[RATE_WIDTH-1:0];
    stall_d = '0;
    if (delta == '0) begin
      stall_d = (stall_q == SW'(STALL_WINDOWS)) ? stall_q : stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= STATE_PRIME;
      baseline_q   <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      saturated_q  <= 1'b0;
      stalled_q    <= 1'b0;
      stall_q      <= '0;
    end else begin
      rate_valid_q <= 1'b0;
      if (tick) begin
        baseline_q <= bus.count;
        case (state_q)
          STATE_PRIME: begin
            state_q <= STATE_RUN;
          end
          STATE_RUN: begin
            rate_q       <= rate_d;
            saturated_q  <= over;
            rate_valid_q <= 1'b1;
            stall_q      <= stall_d;
            stalled_q    <= (stall_d == SW'(STALL_WINDOWS));
          end
          default: begin
            state_q <= STATE_PRIME;
          end
        endcase
      end
    end
  end

  assign bus.rate      = rate_q;
  assign bus.rateValid = rate_valid_q;
  assign bus.saturated = saturated_q;
  assign bus.stalled   = stalled_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_forwarded_count_rate.sv
// tb_forwarded_count_rate
// Two meters side by side: A uses the internal divider (10-cycle windows,
// 8-bit rate), B uses the external strobe (32-bit rate). A reference model
// keeps the counts sampled at each window edge and derives rate, saturation
// and stall from that history; outputs are compared on every cycle.
module tb_forwarded_count_rate;
  import forwarded_count_rate_pkg::*;

  localparam int WIN   = 10;
  localparam int STALL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forwarded_count_rate_if #(.COUNT_WIDTH(32), .RATE_WIDTH(8))  ifa ();
  forwarded_count_rate_if #(.COUNT_WIDTH(32), .RATE_WIDTH(32)) ifb ();

  forwarded_count_rate #(
    .COUNT_WIDTH(32), .RATE_WIDTH(8), .WINDOW_CYCLES(WIN),
    .USE_EXT_STROBE(1'b0), .STALL_WINDOWS(STALL)
  ) dut_a (.clk(clk), .reset(rst), .bus(ifa));

  forwarded_count_rate #(
    .COUNT_WIDTH(32), .RATE_WIDTH(32), .WINDOW_CYCLES(WIN),
    .USE_EXT_STROBE(1'b1), .STALL_WINDOWS(STALL)
  ) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_a_q[$];
  logic [31:0] exp_b_q[$];

  logic [31:0] hist [2][STALL+1];
  int          nsamp [2];
  logic        ev [2];
  logic [31:0] er [2];
  logic        es [2];
  logic        est [2];
  int unsigned pos_a;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predicts the outputs after the coming clock edge from the inputs now applied.
  task automatic model_edge(input int i, input logic [31:0] c, input logic strobe);
    logic        tick;
    logic [31:0] d;
    logic [31:0] maxv;
    bit          all_zero;
    if (rst) begin
      nsamp[i] = 0;
      ev[i] = 1'b0; er[i] = '0; es[i] = 1'b0; est[i] = 1'b0;
      if (i == 0) pos_a = 0;
      return;
    end
    if (i == 0) begin
      tick = ((pos_a % WIN) == WIN - 1);
      pos_a++;
    end else begin
      tick = strobe;
    end
    ev[i] = 1'b0;
    if (!tick) return;
    for (int k = 0; k < STALL; k++) hist[i][k] = hist[i][k+1];
    hist[i][STALL] = c;
    if (nsamp[i] < STALL + 1) nsamp[i]++;
    if (nsamp[i] < 2) return;
    d    = hist[i][STALL] - hist[i][STALL-1];
    maxv = (i == 0) ? 32'hFF : 32'hFFFF_FFFF;
    ev[i] = 1'b1;
    er[i] = (d > maxv) ? maxv : d;
    es[i] = (d > maxv);
    all_zero = (nsamp[i] == STALL + 1);
    for (int k = 1; k <= STALL; k++) if (hist[i][k] != hist[i][k-1]) all_zero = 0;
    est[i] = all_zero;
    if (i == 0) exp_a_q.push_back(er[i]);
    else        exp_b_q.push_back(er[i]);
  endtask

  task automatic compare_all();
    check("a_valid", ifa.rateValid, ev[0]);
    if (ifa.rateValid) begin
      if (exp_a_q.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else check("a_rate_q", {24'b0, ifa.rate}, exp_a_q.pop_front());
    end
    check("a_rate", {24'b0, ifa.rate}, er[0]);
    check("a_sat", ifa.saturated, es[0]);
    check("a_stalled", ifa.stalled, est[0]);
    check("b_valid", ifb.rateValid, ev[1]);
    if (ifb.rateValid) begin
      if (exp_b_q.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
      else check("b_rate_q", ifb.rate, exp_b_q.pop_front());
    end
    check("b_rate", ifb.rate, er[1]);
    check("b_sat", ifb.saturated, es[1]);
    check("b_stalled", ifb.stalled, est[1]);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    model_edge(0, ifa.count, ifa.windowStrobe);
    model_edge(1, ifb.count, ifb.windowStrobe);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    pos_a = 0;
    for (int i = 0; i < 2; i++) begin
      nsamp[i] = 0; ev[i] = 0; er[i] = 0; es[i] = 0; est[i] = 0;
      for (int k = 0; k <= STALL; k++) hist[i][k] = '0;
    end
    rst = 1'b1;
    ifa.count = '0; ifa.windowStrobe = 1'b0;
    ifb.count = '0; ifb.windowStrobe = 1'b0;
    step();
    step();
    check("reset_a_rate", {24'b0, ifa.rate}, 32'd0);
    check("reset_a_valid", ifa.rateValid, 32'd0);
    check("reset_b_stalled", ifb.stalled, 32'd0);
    check("reset_a_state", ifa.dbg_state, STATE_PRIME);
    rst = 1'b0;

    // Directed: steady rate, wrap, saturation, stall, external strobes.
    for (int p = 0; p < 165; p++) begin
      if      (p < 60)  ifa.count = 32'(3 * (p / 10));
      else if (p < 70)  ifa.count = 32'hFFFF_FFFE;
      else if (p < 80)  ifa.count = 32'd3;
      else if (p < 90)  ifa.count = 32'd303;
      else if (p < 100) ifa.count = 32'd310;
      else if (p < 150) ifa.count = 32'd42;
      else              ifa.count = (p < 160) ? 32'd43 : 32'd50;
      ifb.windowStrobe = (p == 5 || p == 6 || p == 50 || (p >= 100 && p <= 105));
      ifb.count = (p >= 6) ? 32'd9 : 32'd0;
      step();
      case (p)
        6:   begin check("t5_b_valid", ifb.rateValid, 32'd1); check("t5_b_rate9", ifb.rate, 32'd9); end
        9:   begin check("t1_no_first", ifa.rateValid, 32'd0); check("t1_state_run", ifa.dbg_state, STATE_RUN); end
        19:  begin check("t1_valid", ifa.rateValid, 32'd1); check("t1_rate3", {24'b0, ifa.rate}, 32'd3); end
        29:  begin check("t1_rate3b", {24'b0, ifa.rate}, 32'd3); check("t1_sat0", ifa.saturated, 32'd0); end
        50:  begin check("t5_b_valid50", ifb.rateValid, 32'd1); check("t5_b_rate0", ifb.rate, 32'd0); end
        79:  begin check("t2_wrap5", {24'b0, ifa.rate}, 32'd5); check("t2_sat0", ifa.saturated, 32'd0); end
        89:  begin check("t3_clamp", {24'b0, ifa.rate}, 32'd255); check("t3_sat1", ifa.saturated, 32'd1); end
        99:  begin check("t3_rate7", {24'b0, ifa.rate}, 32'd7); check("t3_sat0", ifa.saturated, 32'd0); end
        139: check("t4_not_yet", ifa.stalled, 32'd0);
        149: begin check("t4_stalled", ifa.stalled, 32'd1); check("t4_valid", ifa.rateValid, 32'd1); end
        159: begin check("t4_rate1", {24'b0, ifa.rate}, 32'd1); check("t4_unstall", ifa.stalled, 32'd0); end
        default: ;
      endcase
    end

    // Reset mid-window with a pending delta.
    rst = 1'b1;
    step();
    check("t6_rate0", {24'b0, ifa.rate}, 32'd0);
    check("t6_b_stalled0", ifb.stalled, 32'd0);
    rst = 1'b0;
    for (int q = 0; q < 25; q++) begin
      ifa.count = 32'(60 + 2 * (q / 10));
      ifb.windowStrobe = 1'b0;
      step();
      if (q == 9)  check("t6_no_first", ifa.rateValid, 32'd0);
      if (q == 19) begin check("t6_valid", ifa.rateValid, 32'd1); check("t6_rate2", {24'b0, ifa.rate}, 32'd2); end
    end

    // Randomized traffic with frozen stretches and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      bit frozen;
      frozen = (((n / 200) % 3) == 2);
      if (!frozen) begin
        if ($urandom_range(0, 3) == 0) ifa.count = ifa.count + 32'($urandom_range(0, 40));
        if ($urandom_range(0, 199) == 0) ifa.count = ifa.count + $urandom;
        if ($urandom_range(0, 2) == 0) ifb.count = ifb.count + 32'($urandom_range(0, 1000));
        if ($urandom_range(0, 299) == 0) ifb.count = $urandom;
      end
      ifa.windowStrobe = 1'($urandom_range(0, 1));
      ifb.windowStrobe = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    ifb.windowStrobe = 1'b0;
    for (int n = 0; n < 3; n++) step();
    check("a_queue_drained", exp_a_q.size(), 32'd0);
    check("b_queue_drained", exp_b_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/forwarded_count_rate.md
Name: forwarded_count_rate

Overview:
- Consumer stage that sits directly downstream of the clock-domain data forwarder, in the destination (system) clock domain.
- Takes a free-running event/cycle count that has been forwarded from a foreign clock domain and samples it once per measurement window.
- Publishes the modulo-2^W difference as a rate, together with a valid strobe, saturation and stall flags.
- Feeds the status/CSR readout of event rates (e.g. event-link rates, reference-clock frequency).

Parameters:
COUNT_WIDTH, 32, width of forwarded count input.
RATE_WIDTH, 32, width of rate output; must be <= COUNT_WIDTH.
WINDOW_CYCLES, 125000000, clk cycles per window when the internal divider is used; >= 2.
USE_EXT_STROBE, 0, 1 = windows delimited by windowStrobe instead of the internal divider.
STALL_WINDOWS, 4, consecutive zero-delta windows before stalled asserts; >= 1.

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  synchronous, active-high reset.
count  input  COUNT_WIDTH  forwarded count; updates at arbitrary, infrequent clk edges, is stable between updates and is never metastable.
windowStrobe  input  1  single-cycle window boundary; ignored when USE_EXT_STROBE=0.
rate  output  RATE_WIDTH  count delta over the last complete window.
rateValid  output  1  one-cycle pulse when rate updates.
saturated  output  1  last delta exceeded 2^RATE_WIDTH-1; rate clamped.
stalled  output  1  count unchanged for STALL_WINDOWS consecutive windows.

Behaviour:
- Reset values: rate=0, rateValid=0, saturated=0, stalled=0. Divider is 0, baseline is 0, state is PRIME, stall counter is 0.
- Reset mid-window discards that window. No output is produced until a full window follows reset.
- Window edge (tick):
  - USE_EXT_STROBE=0: the divider counts 0..WINDOW_CYCLES-1; tick is asserted on the cycle the divider equals WINDOW_CYCLES-1, and the divider then wraps to 0.
  - USE_EXT_STROBE=1: tick = windowStrobe; the divider is unused.
- State PRIME: on tick, baseline <= count; go to RUN. No rateValid is produced.
- State RUN: on tick, compute delta = (count - baseline) mod 2^COUNT_WIDTH, then baseline <= count. A count that wraps past all-ones therefore yields the correct positive delta.
- Registered output, latency 1 clk: rate, saturated and rateValid=1 appear on the cycle after tick. rateValid is 0 on all other cycles.
- Saturation: if delta > 2^RATE_WIDTH-1, then rate = all-ones and saturated=1; otherwise saturated=0. saturated is updated only when rateValid pulses.
- Stall counter:
  - On each RUN tick with delta==0, increment, saturating at STALL_WINDOWS.
  - Any tick with delta!=0 clears it to 0.
  - stalled = (stall counter == STALL_WINDOWS); it changes only on the rateValid cycle.
- count changing on the same cycle as tick: the value present on that cycle is sampled. The update is then counted in this window; no double count or loss across windows.
- windowStrobe asserted on consecutive cycles: each cycle is a separate window. Deltas are typically 0 and feed the stall counter.
- Count is sampled only at tick; intermediate values are ignored.

Decomposition:
- Shared package: STATE_PRIME/STATE_RUN encodings and the helper function for the saturating width reduction (delta to RATE_WIDTH plus flag).
- One natural sub-module: window_divider (divider producing the tick, bypassed when USE_EXT_STROBE=1).
- The delta, saturation and stall logic stays in the top module.

Test Plan:
1. WINDOW_CYCLES=10, count +3 every window (0,3,6,...):
   - first rateValid is in the 2nd window, with rate=3; no pulse in window 1.
   - then rate=3 every 10 clks; saturated=0, stalled=0.
2. Wrap-around: baseline 0xFFFFFFFE, count 0x00000003 at next tick -> rate=5, saturated=0.
3. RATE_WIDTH=8, delta 300 -> rate=255, saturated=1; a following delta of 7 -> rate=7, saturated=0.
4. STALL_WINDOWS=4, count frozen at 42:
   - stalled rises with the 4th zero-delta rateValid;
   - count +1 -> next rateValid has rate=1, stalled=0.
5. USE_EXT_STROBE=1, strobes at cycles 5, 6, 50, with count stepping 0->9 at cycle 6 (same cycle as the strobe):
   - cycle-5 tick primes the baseline to 0; cycle-6 tick samples 9, so rateValid at cycle 7 with rate=9;
   - cycle-50 tick gives rateValid at cycle 51 with rate=0.
6. Reset asserted mid-window in RUN with a pending delta:
   - all outputs are 0 the next cycle;
   - no rateValid in the first window after reset; a valid rate follows after that.
